// File: rtl/seq_alu_if.sv
// seq_alu_if: ready/valid operand and result bus of seq_alu
interface seq_alu_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, out_valid, out_ready, illegal;
  logic [15:0] instr;
  logic [WIDTH-1:0] rn, rm, rd;
  logic [3:0] flags;
  modport master (output in_valid, instr, rn, rm, out_ready, input in_ready, out_valid, rd, flags, illegal);
  modport slave (input in_valid, instr, rn, rm, out_ready, output in_ready, out_valid, rd, flags, illegal);
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered A-type ALU with N/Z/C/V flags and ready/valid handshake
// SEQ_ALU_MUL_EN adds the multi-cycle shift-add multiplier (op 5)
module seq_alu #(parameter int WIDTH = 16) (
  input logic clk,
  input logic reset,
  seq_alu_if.slave bus
);
  localparam logic [4:0] OP_ADD = 5'd0, OP_EQUAL = 5'd1, OP_OR = 5'd2, OP_AND = 5'd3, OP_MINUS = 5'd4;
`ifdef SEQ_ALU_MUL_EN
  localparam logic [4:0] OP_MUL = 5'd5, OP_MAX = 5'd5;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  logic [2*WIDTH-1:0] prod, mcand;
  logic [WIDTH-1:0] mplr, cnt;
`else
  localparam logic [4:0] OP_MAX = 5'd4;
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif
  localparam int M = WIDTH - 1;
  state_t state, nxt;
  logic [4:0] op;
  logic a_type, is_mul, acc, fin, ill, c, v;
  logic [WIDTH:0] sum, dif;
  logic [WIDTH-1:0] res;
  logic [3:0] fl;
  always_comb begin
    op = bus.instr[13:9];
    a_type = bus.instr[15:14] == 2'b00;
    sum = {1'b0, bus.rn} + {1'b0, bus.rm};
    dif = {1'b0, bus.rn} + {1'b0, ~bus.rm} + 1'b1;
    ill = a_type && op > OP_MAX;
    res = !a_type || ill ? '0 :
          op == OP_ADD   ? sum[M:0] :
          op == OP_EQUAL ? bus.rn :
          op == OP_OR    ? bus.rn | bus.rm :
          op == OP_AND   ? bus.rn & bus.rm :
          op == OP_MINUS ? dif[M:0] : '0;
    c = a_type && (op == OP_ADD ? sum[WIDTH] : op == OP_MINUS ? dif[WIDTH] : 1'b0);
    v = a_type && (op == OP_ADD ? bus.rn[M] == bus.rm[M] && sum[M] != bus.rn[M] :
                   op == OP_MINUS ? bus.rn[M] != bus.rm[M] && dif[M] != bus.rn[M] : 1'b0);
    fl = a_type && !ill ? {res[M], res == '0, c, v} : 4'b0000;
`ifdef SEQ_ALU_MUL_EN
    is_mul = a_type && op == OP_MUL;
    fin = state == BUSY && cnt == WIDTH'(WIDTH);
`else
    is_mul = 1'b0;
    fin = 1'b0;
`endif
    bus.in_ready = state == IDLE || (state == DONE && bus.out_ready);
    bus.out_valid = state == DONE;
    acc = bus.in_valid && bus.in_ready;
`ifdef SEQ_ALU_MUL_EN
    nxt = acc ? (is_mul ? BUSY : DONE) : fin ? DONE : (state == DONE && bus.out_ready) ? IDLE : state;
`else
    nxt = acc ? DONE : (state == DONE && bus.out_ready) ? IDLE : state;
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bus.rd <= '0;
      bus.flags <= '0;
      bus.illegal <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      prod <= '0;
      mcand <= '0;
      mplr <= '0;
      cnt <= '0;
`endif
    end else begin
      state <= nxt;
      if (acc && !is_mul) begin
        bus.rd <= res;
        bus.flags <= fl;
        bus.illegal <= ill;
      end
`ifdef SEQ_ALU_MUL_EN
      // operands are captured here so later input changes cannot disturb the product
      if (acc && is_mul) begin
        prod <= '0;
        mcand <= {{WIDTH{1'b0}}, bus.rn};
        mplr <= bus.rm;
        cnt <= '0;
      end else if (state == BUSY && !fin) begin
        prod <= mplr[0] ? prod + mcand : prod;
        mcand <= mcand << 1;
        mplr <= mplr >> 1;
        cnt <= cnt + 1'b1;
      end
      if (fin) begin
        bus.rd <= prod[M:0];
        bus.flags <= {prod[M], prod[M:0] == '0, |prod[2*WIDTH-1:WIDTH], 1'b0};
        bus.illegal <= 1'b0;
      end
`endif
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: table-driven vectors plus back-pressure, reset and multiply sequences
module tb_seq_alu;
  localparam int W = 16;
  localparam logic [4:0] ADD = 5'd0, EQU = 5'd1, ORR = 5'd2, ANDD = 5'd3, SUB = 5'd4, MUL = 5'd5;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0, fails = 0;
  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] instr;
    logic [W-1:0] rn, rm, rd;
    logic [3:0] flags;
    logic ill;
  } vec_t;
  vec_t v [12];
  function automatic logic [15:0] ins(input logic [1:0] t, input logic [4:0] op);
    return {t, op, 9'd0};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = 1'b1;
    bus.instr = i;
    bus.rn = a;
    bus.rm = b;
    tick;
    bus.in_valid = 1'b0;
  endtask
`ifdef SEQ_ALU_MUL_EN
  task automatic mul_run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] erd, input logic [3:0] efl);
    int lat, busy_bad;
    send(ins(2'b00, MUL), a, b);
    bus.rn = '1;
    bus.rm = '1;
    lat = 0;
    busy_bad = 0;
    do begin
      if (bus.in_ready || bus.out_valid) busy_bad++;
      tick;
      lat++;
    end while (!bus.out_valid && lat < 40);
    chk("mul_busy", busy_bad, 0);
    chk("mul_latency", lat, 17);
    chk("mul_rd", bus.rd, erd);
    chk("mul_flags", bus.flags, efl);
    chk("mul_illegal", bus.illegal, 0);
    tick;
  endtask
`endif
  initial begin
    bus.in_valid = 1'b0;
    bus.instr = '0;
    bus.rn = '0;
    bus.rm = '0;
    bus.out_ready = 1'b1;
    v[0]  = '{ins(2'b00, ADD),  16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1'b0};
    v[1]  = '{ins(2'b00, SUB),  16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 1'b0};
    v[2]  = '{ins(2'b00, SUB),  16'h0001, 16'h0002, 16'hFFFF, 4'b1000, 1'b0};
    v[3]  = '{ins(2'b00, EQU),  16'h1234, 16'hABCD, 16'h1234, 4'b0000, 1'b0};
    v[4]  = '{ins(2'b00, ORR),  16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000, 1'b0};
    v[5]  = '{ins(2'b00, ANDD), 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1'b0};
    v[6]  = '{ins(2'b00, ADD),  16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b0};
    v[7]  = '{ins(2'b00, 5'd7), 16'h1111, 16'h2222, 16'h0000, 4'b0000, 1'b1};
    v[8]  = '{ins(2'b01, ADD),  16'h0001, 16'h0001, 16'h0000, 4'b0000, 1'b0};
    v[9]  = '{ins(2'b00, ANDD), 16'h00FF, 16'hFF00, 16'h0000, 4'b0100, 1'b0};
    v[10] = '{ins(2'b00, 5'd31), 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0000, 1'b1};
    v[11] = '{ins(2'b00, SUB),  16'h0005, 16'h0005, 16'h0000, 4'b0110, 1'b0};
    tick;
    tick;
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_rd", bus.rd, 0);
    chk("reset_flags", bus.flags, 0);
    chk("reset_illegal", bus.illegal, 0);
    chk("reset_ready", bus.in_ready, 1);
    reset = 1'b0;
    tick;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("vec%0d_ready", i), bus.in_ready, 1);
      send(v[i].instr, v[i].rn, v[i].rm);
      chk($sformatf("vec%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("vec%0d_rd", i), bus.rd, v[i].rd);
      chk($sformatf("vec%0d_flags", i), bus.flags, v[i].flags);
      chk($sformatf("vec%0d_illegal", i), bus.illegal, v[i].ill);
    end
    tick;
    chk("drain_idle", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    send(ins(2'b00, ADD), 16'd2, 16'd3);
    chk("bp_valid", bus.out_valid, 1);
    bus.in_valid = 1'b1;
    bus.instr = ins(2'b00, ORR);
    bus.rn = 16'h00F0;
    bus.rm = 16'h0F00;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rd_hold", bus.rd, 16'd5);
      chk("bp_flags_hold", bus.flags, 0);
      chk("bp_in_ready", bus.in_ready, 0);
      tick;
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_ready_follows", bus.in_ready, 1);
    chk("bp_rd_before", bus.rd, 16'd5);
    tick;
    bus.in_valid = 1'b0;
    chk("bp_next_valid", bus.out_valid, 1);
    chk("bp_next_rd", bus.rd, 16'h0FF0);
    tick;
    bus.out_ready = 1'b0;
    send(ins(2'b00, ADD), 16'd1, 16'd1);
    chk("rst_done_valid", bus.out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_done_cleared", bus.out_valid, 0);
    chk("rst_done_rd", bus.rd, 0);
    tick;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    tick;
`ifdef SEQ_ALU_MUL_EN
    mul_run(16'd300, 16'd200, 16'hEA60, 4'b1000);
    mul_run(16'h0100, 16'h0100, 16'h0000, 4'b0110);
    mul_run(16'd300, 16'd200, 16'hEA60, 4'b1000);
    send(ins(2'b00, MUL), 16'd300, 16'd200);
    repeat (8) tick;
    chk("mid_mul_busy", bus.in_ready, 0);
    reset = 1'b1;
    #1;
    chk("mid_mul_valid", bus.out_valid, 0);
    chk("mid_mul_rd", bus.rd, 0);
    chk("mid_mul_idle", bus.in_ready, 1);
    tick;
    reset = 1'b0;
    tick;
    send(ins(2'b00, ADD), 16'd2, 16'd3);
    chk("after_rst_valid", bus.out_valid, 1);
    chk("after_rst_rd", bus.rd, 16'd5);
`else
    send(ins(2'b00, MUL), 16'd300, 16'd200);
    chk("nomul_valid", bus.out_valid, 1);
    chk("nomul_illegal", bus.illegal, 1);
    chk("nomul_rd", bus.rd, 0);
    chk("nomul_flags", bus.flags, 0);
`endif
    tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the combinational A-type ALU. It registers its result and adds status flags (N/Z/C/V), an illegal-opcode indication and an optional multi-cycle shift-add multiplier. It sits between the register-read and write-back stages. Ready/valid on both sides lets the datapath stall on a busy multiply or on write-back back-pressure.

## Interface
- WIDTH, 16, operand/result width in bits (≥4)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operands and instr presented
- in_ready  out  1  block accepts on in_valid & in_ready at a rising edge
- instr  in  16  instruction: [15:14] type (A-type = 2'b00), [13:9] op
- rn  in  WIDTH  operand A
- rm  in  WIDTH  operand B
- out_valid  out  1  result held on rd/flags/illegal
- out_ready  in  1  consumer takes result on out_valid & out_ready
- rd  out  WIDTH  result
- flags  out  4  {N,Z,C,V}
- illegal  out  1  A-type with undefined op

## Operation
- Op encodings: ADD=0, EQUAL=1 (rd=rn), OR=2, AND=3, MINUS=4 (rn+~rm+1), MUL=5. Ops 6–31 are undefined.
- States:
  - IDLE: in_ready=1.
  - BUSY: MUL iterating, in_ready=0.
  - DONE: out_valid=1, in_ready=out_ready.
- Transitions:
  - IDLE/DONE accept of non-MUL → DONE.
  - IDLE/DONE accept of MUL → BUSY.
  - DONE with out_ready and no accept → IDLE.
  - BUSY after WIDTH iterations → DONE.
- Non-A-type instr: accepted; rd=0, flags=0, illegal=0.
- Undefined op: rd=0, flags=0, illegal=1.
- Flags:
  - Z = (rd==0). N = rd[WIDTH-1].
  - ADD: C = carry out of bit WIDTH-1; V = signed overflow.
  - MINUS: C = no borrow (rn ≥ rm unsigned); V = signed overflow.
  - EQUAL/OR/AND: C=V=0.
  - MUL: rd = low WIDTH bits of the unsigned product; C = (high WIDTH bits ≠ 0); V=0.
- MUL: shift-add, one multiplier bit per cycle, LSB first, WIDTH-wide iteration counter. Operands are captured at acceptance and input changes do not affect the result.
- Holding: while out_valid & !out_ready, rd/flags/illegal stay stable.

## Timing
- Reset (async assert; deassert sampled at clk): state=IDLE, out_valid=0, rd=0, flags=0, illegal=0, counter=0. in_ready=1 after reset.
- Acceptance edge = edge 0.
- Non-MUL: out_valid=1 after edge 1 (latency 1).
- MUL: iterations on edges 1..WIDTH; out_valid=1 after edge WIDTH+1.
- Throughput: one non-MUL per cycle with out_ready held high. In DONE, an accept and a drain on the same edge replaces the result with no bubble.
- in_ready is combinational from state and out_ready; there is no path from in_valid to in_ready.
- Reset during BUSY or DONE aborts the operation and discards any pending result.
- in_valid while in_ready=0: ignored; the producer must hold it.

## Configuration
- SEQ_ALU_MUL_EN defined:
  - MUL implemented as above.
  - BUSY state and iteration counter present.
- Not defined:
  - op 5 is treated as undefined: illegal=1, rd=0, latency 1.
  - No BUSY state; in_ready = !out_valid | out_ready.

## Test plan
- ADD rn=0xFFFF, rm=0x0001 (WIDTH=16) → rd=0x0000, flags N=0 Z=1 C=1 V=0, out_valid after edge 1.
- MINUS rn=0x8000, rm=0x0001 → rd=0x7FFF, N=0 Z=0 C=1 V=1. MINUS 0x0001−0x0002 → rd=0xFFFF, N=1, C=0.
- MUL 300×200 (with SEQ_ALU_MUL_EN) → rd=0xEA60, C=0, out_valid after edge 17, in_ready=0 during edges 1–16. MUL 0x0100×0x0100 → rd=0, Z=1, C=1.
- Back-pressure: ADD accepted, out_ready=0 for 5 cycles → rd/flags constant, in_ready=0. Raise out_ready together with a new OR 0x00F0|0x0F00 → ADD result drains and rd=0x0FF0 on the next cycle.
- Reset asserted mid-MUL (edge 8) → out_valid=0 and rd=0 immediately, state IDLE. A following ADD 2+3 returns rd=5 with latency 1.
- instr op=7 → illegal=1, rd=0. Type 2'b01 → rd=0, illegal=0. Without the macro, MUL → illegal=1.
